sensor_stream_packer: RTL
=========================

# sensor_stream_packer

- Sits inside SimpleRole, directly downstream of Role's softreg and PCIe conversion.
- Captures a free-running thermal-sensor count (ring-oscillator / TDC value) at a software-programmed period.
- Packs the captures four to a beat into PCIe-width beats, buffers them, and streams them to the host on the slot DMA output as fixed-size packets.
- Software configures and starts a run through soft registers, then reads status to detect completion and dropped samples.

## Interface
- SAMPLE_WIDTH, 32, width of one sensor sample; PCIE_DATA_WIDTH / SAMPLE_WIDTH = 4 lanes per beat.
- FIFO_DEPTH, 16, beat buffer depth; power of two.
- PKT_BEATS, 8, beats per PCIe packet; `last` is set on every PKT_BEATS-th beat.
- clk  in  1  user clock; the block runs on one clock.
- rst  in  1  reset; synchronous, active-high.
- sample_in  in  SAMPLE_WIDTH  current sensor count; stable each cycle, no valid.
- softreg_req  in  SoftRegReq  {valid, isWrite, addr, data}.
- softreg_resp  out  SoftRegResp  {valid, data}; read response.
- pcie_packet_out  out  PCIEPacket  {valid, data, slot, pad, last}.
- pcie_grant_in  in  1  host pop; a beat transfers when valid && grant in the same cycle.

## Operation
- Registers (addr[3:0]):
  - 0 CTRL (W): bit0 start, bit1 abort.
  - 1 PERIOD (RW, 32b): 0 behaves as 1.
  - 2 NUM_BEATS (RW, 16b): 0 means the run ends immediately.
  - 3 SLOT (RW, PCIE_SLOT_WIDTH).
  - 4 STATUS (R): {drop_count[31:0], beats_sent[15:0], 13'b0, done, state[1:0]}.
  - Other addresses read 0; writes to them are ignored.
- A read returns the register value sampled on the request cycle.
- States: IDLE=0, RUN=1, DRAIN=2.
  - IDLE→RUN on start when NUM_BEATS≠0. This clears done, beats_enq, beats_sent, drop_count, period counter and lane index.
  - Start with NUM_BEATS=0 sets done and stays in IDLE.
  - RUN→DRAIN when beats_enq reaches NUM_BEATS.
  - DRAIN→IDLE when the FIFO is empty and the pack register is empty; done is set on that transition.
  - Start in RUN or DRAIN is ignored.
  - Abort in any state: go to IDLE, flush FIFO and pack register, leave done=0. Abort wins over start when both are set in one write.
- Capture, RUN only:
  - The period counter counts 0..PERIOD-1; the capture happens on the cycle it equals PERIOD-1.
  - sample_in is written to lane[lane_idx], placing sample k at data bits [32k+31:32k].
  - After lane 3 the beat is marked full.
- Full beat handling:
  - A full beat moves to the FIFO on the next cycle the FIFO is not full. beats_enq then increments and the lanes are free again.
  - A capture that arrives while the beat is still full is dropped. drop_count increments, saturating at all-ones, and the period counter keeps running.
- Each FIFO entry stores {data, last}. last = 1 when (beats_enq+1) % PKT_BEATS == 0 or beats_enq+1 == NUM_BEATS.
- Output fields:
  - valid = FIFO not empty.
  - slot = SLOT register latched at start.
  - pad = 0.
  - On pop, beats_sent increments.
- PERIOD, NUM_BEATS and SLOT writes during RUN/DRAIN take effect at the next start only; the block uses values latched at start.

## Timing
- Reset values:
  - Outputs: softreg_resp.valid=0 and data=0; pcie_packet_out all fields 0.
  - State and counters: state IDLE, done=0, all counters 0.
  - Registers: PERIOD=1, NUM_BEATS=0, SLOT=0.
- Soft register read latency: the response is valid exactly 1 cycle after the request, for 1 cycle. Writes have no response.
- Run start: the start write is cycle 0; state=RUN at cycle 1; the first capture is at cycle PERIOD.
- Buffering latency: the cycle after lane 3 is captured, the beat enters the FIFO if there is room; valid is seen the cycle after that (FIFO registered output).
- Back-to-back pops at 1 beat/cycle while grant is held.
- A simultaneous push and pop on a full FIFO is allowed. A pop on an empty FIFO is a no-op.
- Wrap-around: the FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from an MSB compare.
- Abort mid-transfer: valid=0 on the cycle after the abort write; a grant in that cycle is ignored.

## Structure
- Add to ShellTypes: SensorStreamState enum (IDLE/RUN/DRAIN) and the softreg address constants SSP_CTRL … SSP_STATUS.
- Sub-module sensor_beat_fifo:
  - Synchronous FIFO, parameters WIDTH and DEPTH, registered outputs.
  - Ports: push/pop, full/empty, count, and a flush input.
- The top level holds the softreg decode, FSM, period counter and packer.

## Test plan
- PERIOD=3, NUM_BEATS=2, PKT_BEATS=8, sample_in = cycle count, grant held high:
  - 2 beats out, the second with last=1.
  - Lane values are 3 apart.
  - The first sample is the count at cycle 3.
  - done=1 afterwards, STATUS beats_sent=2.
- NUM_BEATS=20, PKT_BEATS=8, PERIOD=1, grant high:
  - last is set on beats 8, 16 and 20 only.
  - slot on every beat equals the programmed SLOT.
- PERIOD=1, NUM_BEATS=40, grant low for 200 cycles then high:
  - 16 beats are buffered plus 1 pending.
  - drop_count>0; all 40 beats are delivered and in order.
  - No beat is lost, only samples.
- Abort written mid-RUN with 5 beats buffered:
  - valid=0 on the next cycle, state=IDLE, done=0.
  - A following start runs cleanly from beats_sent=0.
- Corner writes:
  - start with NUM_BEATS=0 → done=1, no beats.
  - start+abort in one write → IDLE.
  - PERIOD=0 → captures every cycle.
  - Read of addr 7 → 0, one cycle later.
- rst asserted mid-DRAIN: all outputs and counters reach their reset values on the next edge.

Source files
------------

// File: rtl/sensor_stream_packer_pkg.sv
// Shared types and constants for the thermal-sensor stream packer.
// The softreg and PCIe packet layouts match the surrounding role shell.
package sensor_stream_packer_pkg;

  localparam int SAMPLE_WIDTH       = 32;
  localparam int PCIE_DATA_WIDTH    = 128;
  localparam int LANES              = PCIE_DATA_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_AW            = $clog2(LANES);
  localparam int PCIE_SLOT_WIDTH    = 16;
  localparam int PCIE_PAD_WIDTH     = 4;
  localparam int FIFO_DEPTH         = 16;
  localparam int PKT_BEATS          = 8;
  localparam int PKT_AW             = $clog2(PKT_BEATS);
  localparam int SOFTREG_ADDR_WIDTH = 32;
  localparam int SOFTREG_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sensor_stream_state_e;

  localparam logic [3:0] SSP_CTRL      = 4'd0;
  localparam logic [3:0] SSP_PERIOD    = 4'd1;
  localparam logic [3:0] SSP_NUM_BEATS = 4'd2;
  localparam logic [3:0] SSP_SLOT      = 4'd3;
  localparam logic [3:0] SSP_STATUS    = 4'd4;

  typedef struct packed {
    logic                          valid;
    logic                          is_write;
    logic [SOFTREG_ADDR_WIDTH-1:0] addr;
    logic [SOFTREG_DATA_WIDTH-1:0] data;
  } soft_reg_req_t;

  typedef struct packed {
    logic                          valid;
    logic [SOFTREG_DATA_WIDTH-1:0] data;
  } soft_reg_resp_t;

  typedef struct packed {
    logic                       valid;
    logic [PCIE_DATA_WIDTH-1:0] data;
    logic [PCIE_SLOT_WIDTH-1:0] slot;
    logic [PCIE_PAD_WIDTH-1:0]  pad;
    logic                       last;
  } pcie_packet_t;

endpackage

// File: rtl/sensor_stream_packer_if.sv
// Bundle of the sensor, softreg and PCIe DMA signals seen by the packer.
// The slave view is the packer itself; the master view is the shell/host side.
interface sensor_stream_packer_if;
  import sensor_stream_packer_pkg::*;

  logic [SAMPLE_WIDTH-1:0] sample_in;
  soft_reg_req_t           softreg_req;
  soft_reg_resp_t          softreg_resp;
  pcie_packet_t            pcie_packet_out;
  logic                    pcie_grant_in;

  modport master (
    output sample_in, softreg_req, pcie_grant_in,
    input  softreg_resp, pcie_packet_out
  );

  modport slave (
    input  sample_in, softreg_req, pcie_grant_in,
    output softreg_resp, pcie_packet_out
  );

endinterface

// File: rtl/sensor_beat_fifo.sv
// Synchronous beat FIFO with flush; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB compare.
module sensor_beat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sensor_stream_packer.sv
// Captures the thermal-sensor count at a programmed period, packs four samples
// per beat and streams fixed-size packets to the host through a beat FIFO.
module sensor_stream_packer
  import sensor_stream_packer_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  sensor_stream_packer_if.slave bus
);
  localparam int                 FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam logic [LANE_AW-1:0] LAST_LANE = LANE_AW'(LANES - 1);

  sensor_stream_state_e          state;
  logic                          done;
  logic [31:0]                   period_reg, period_lat, period_cnt, period_max;
  logic [15:0]                   num_beats_reg, num_beats_lat;
  logic [PCIE_SLOT_WIDTH-1:0]    slot_reg, slot_lat;
  logic [LANE_AW-1:0]            lane_idx;
  logic [PCIE_DATA_WIDTH-1:0]    pack_data;
  logic                          pack_full;
  logic [15:0]                   beats_enq, beats_sent, next_enq;
  logic [31:0]                   drop_count;
  soft_reg_resp_t                resp_q;
  logic [SOFTREG_DATA_WIDTH-1:0] rd_data;
  logic [3:0]                    addr;
  logic                          wr_en, rd_en, start, abort, capture, push, pop_fire, last_bit;
  logic [PCIE_DATA_WIDTH:0]      fifo_rdata;
  logic                          fifo_full, fifo_empty;
  logic [FIFO_AW:0]              fifo_count;
  logic                          unused_req_bits;

  assign addr     = bus.softreg_req.addr[3:0];
  assign wr_en    = bus.softreg_req.valid && bus.softreg_req.is_write;
  assign rd_en    = bus.softreg_req.valid && !bus.softreg_req.is_write;
  assign abort    = wr_en && (addr == SSP_CTRL) && bus.softreg_req.data[1];
  assign start    = wr_en && (addr == SSP_CTRL) && bus.softreg_req.data[0] && !bus.softreg_req.data[1];
  assign unused_req_bits = ^{bus.softreg_req.addr[SOFTREG_ADDR_WIDTH-1:4],
                             bus.softreg_req.data[SOFTREG_DATA_WIDTH-1:32]};

  // A programmed period of 0 behaves like 1: capture every cycle.
  assign period_max = (period_lat == '0) ? '0 : period_lat - 1'b1;
  assign capture    = (state == RUN) && (period_cnt == period_max);
  assign pop_fire   = bus.pcie_grant_in && !fifo_empty;
  assign push       = pack_full && (!fifo_full || pop_fire) && !abort;
  assign next_enq   = beats_enq + 1'b1;
  assign last_bit   = (next_enq[PKT_AW-1:0] == '0) || (next_enq == num_beats_lat);

  sensor_beat_fifo #(.WIDTH(PCIE_DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .pop   (bus.pcie_grant_in),
    .wdata ({pack_data, last_bit}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    bus.pcie_packet_out       = '0;
    bus.pcie_packet_out.valid = !fifo_empty;
    bus.pcie_packet_out.data  = fifo_empty ? '0 : fifo_rdata[PCIE_DATA_WIDTH:1];
    bus.pcie_packet_out.last  = !fifo_empty && fifo_rdata[0];
    bus.pcie_packet_out.slot  = slot_lat;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      SSP_PERIOD:    rd_data = {32'd0, period_reg};
      SSP_NUM_BEATS: rd_data = {48'd0, num_beats_reg};
      SSP_SLOT:      rd_data = {{(SOFTREG_DATA_WIDTH - PCIE_SLOT_WIDTH){1'b0}}, slot_reg};
      SSP_STATUS:    rd_data = {drop_count, beats_sent, 13'd0, done, state};
      default:       rd_data = '0;
    endcase
  end

  assign bus.softreg_resp = resp_q;

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q        <= '0;
      state         <= IDLE;
      done          <= 1'b0;
      period_reg    <= 32'd1;
      num_beats_reg <= '0;
      slot_reg      <= '0;
      period_lat    <= 32'd1;
      num_beats_lat <= '0;
      slot_lat      <= '0;
      period_cnt    <= '0;
      lane_idx      <= '0;
      pack_data     <= '0;
      pack_full     <= 1'b0;
      beats_enq     <= '0;
      beats_sent    <= '0;
      drop_count    <= '0;
    end else begin
      resp_q.valid <= rd_en;
      resp_q.data  <= rd_en ? rd_data : '0;

      if (wr_en) begin
        case (addr)
          SSP_PERIOD:    period_reg    <= bus.softreg_req.data[31:0];
          SSP_NUM_BEATS: num_beats_reg <= bus.softreg_req.data[15:0];
          SSP_SLOT:      slot_reg      <= bus.softreg_req.data[PCIE_SLOT_WIDTH-1:0];
          default:       ;
        endcase
      end

      if (pop_fire) beats_sent <= beats_sent + 1'b1;
      if (push) begin
        beats_enq <= next_enq;
        pack_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && num_beats_reg != '0) begin
            state         <= RUN;
            done          <= 1'b0;
            beats_enq     <= '0;
            beats_sent    <= '0;
            drop_count    <= '0;
            period_cnt    <= '0;
            lane_idx      <= '0;
            period_lat    <= period_reg;
            num_beats_lat <= num_beats_reg;
            slot_lat      <= slot_reg;
          end else if (start) begin
            done <= 1'b1;
          end
        end
        RUN: begin
          period_cnt <= (period_cnt == period_max) ? '0 : period_cnt + 1'b1;
          // A capture landing on a still-full beat is lost; the beat itself never is.
          if (capture && pack_full) begin
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
          end else if (capture) begin
            pack_data[lane_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= bus.sample_in;
            lane_idx <= lane_idx + 1'b1;
            if (lane_idx == LAST_LANE) pack_full <= 1'b1;
          end
          if (push && next_enq == num_beats_lat) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_count == '0 && !pack_full) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (abort) begin
        state     <= IDLE;
        done      <= 1'b0;
        pack_full <= 1'b0;
        lane_idx  <= '0;
      end
    end
  end

endmodule
